// File: rtl/feed_sequencer_if.sv
// Handshake and status bundle between the feed controller and its requester.
// The display block consumes feed/duration directly from this bundle.
interface feed_sequencer_if;
    logic        start;
    logic [1:0]  portion;
    logic        abort;
    logic        feed;
    logic [31:0] duration;
    logic [7:0]  seconds_left;
    logic        motor_en;
    logic        busy;
    logic        done;
    logic        rejected;
    logic [15:0] feed_count;

    modport master (
        output start, portion, abort,
        input  feed, duration, seconds_left, motor_en, busy, done, rejected, feed_count
    );

    modport slave (
        input  start, portion, abort,
        output feed, duration, seconds_left, motor_en, busy, done, rejected, feed_count
    );
endinterface

// File: rtl/feed_sequencer.sv
// Turns a one-cycle feed request into a timed feeding session followed by a cooldown.
// Every output is registered; the next values are derived from the next state.
module feed_sequencer #(
    parameter int CLK_HZ     = 50000000,
    parameter int DUR_SMALL  = 4,
    parameter int DUR_MED    = 6,
    parameter int DUR_LARGE  = 11,
    parameter int COOLDOWN_S = 5
) (
    input  logic            clk,
    input  logic            reset,
    feed_sequencer_if.slave bus
);
    localparam int            PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_TC  = PW'(CLK_HZ - 1);
    localparam logic [7:0]    COOL_LAST = 8'(COOLDOWN_S - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FEEDING  = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t        state_r, next_state_s;
    logic [PW-1:0] presc_r, presc_nxt_s;
    logic [7:0]    elapsed_r, elapsed_nxt_s;
    logic [31:0]   duration_r, duration_nxt_s;
    logic          wrap_s;
    logic          done_nxt_s, rejected_nxt_s;
    logic          feed_nxt_s, motor_nxt_s, busy_nxt_s;
    logic [7:0]    seconds_left_nxt_s;

    logic          feed_r, motor_en_r, busy_r, done_r, rejected_r;
    logic [7:0]    seconds_left_r;
    logic [15:0]   feed_count_r;

    function automatic logic [31:0] portion_dur(input logic [1:0] p);
        case (p)
            2'd0:    return 32'(DUR_SMALL);
            2'd1:    return 32'(DUR_MED);
            2'd2:    return 32'(DUR_LARGE);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign wrap_s = (presc_r == PRESC_TC);

    // State register with the second prescaler and elapsed-seconds counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            presc_r    <= '0;
            elapsed_r  <= 8'd0;
            duration_r <= 32'd0;
        end else begin
            state_r    <= next_state_s;
            presc_r    <= presc_nxt_s;
            elapsed_r  <= elapsed_nxt_s;
            duration_r <= duration_nxt_s;
        end
    end

    // Next-state logic; the prescaler and elapsed counter are reused to time the cooldown.
    always_comb begin
        next_state_s   = state_r;
        presc_nxt_s    = presc_r;
        elapsed_nxt_s  = elapsed_r;
        duration_nxt_s = duration_r;
        done_nxt_s     = 1'b0;
        rejected_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                presc_nxt_s   = '0;
                elapsed_nxt_s = 8'd0;
                if (bus.start && !bus.abort) begin
                    if (bus.portion != 2'd3) begin
                        next_state_s   = FEEDING;
                        duration_nxt_s = portion_dur(bus.portion);
                    end else begin
                        rejected_nxt_s = 1'b1;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            FEEDING: begin
                if (bus.abort) begin
                    next_state_s  = COOLDOWN;
                    presc_nxt_s   = '0;
                    elapsed_nxt_s = 8'd0;
                end else if (wrap_s) begin
                    presc_nxt_s = '0;
                    if (elapsed_r == duration_r[7:0]) begin
                        next_state_s  = COOLDOWN;
                        elapsed_nxt_s = 8'd0;
                        done_nxt_s    = 1'b1;
                    end else begin
                        elapsed_nxt_s = elapsed_r + 8'd1;
                    end
                end else begin
                    presc_nxt_s = presc_r + 1'b1;
                end
                // A completion edge outranks a late request so done and rejected stay exclusive.
                rejected_nxt_s = bus.start && !bus.abort && !done_nxt_s;
            end
            COOLDOWN: begin
                if (wrap_s) begin
                    presc_nxt_s = '0;
                    if (elapsed_r == COOL_LAST) begin
                        next_state_s  = IDLE;
                        elapsed_nxt_s = 8'd0;
                    end else begin
                        elapsed_nxt_s = elapsed_r + 8'd1;
                    end
                end else begin
                    presc_nxt_s = presc_r + 1'b1;
                end
                rejected_nxt_s = bus.start;
            end
            default: begin
                next_state_s  = IDLE;
                presc_nxt_s   = '0;
                elapsed_nxt_s = 8'd0;
            end
        endcase
    end

    // Output decode from the upcoming state so outputs line up with it after the register.
    always_comb begin
        feed_nxt_s = (next_state_s == FEEDING);
        busy_nxt_s = (next_state_s != IDLE);
        if (next_state_s == FEEDING) begin
            motor_nxt_s        = (elapsed_nxt_s < duration_nxt_s[7:0]);
            seconds_left_nxt_s = duration_nxt_s[7:0] + 8'd1 - elapsed_nxt_s;
        end else begin
            motor_nxt_s        = 1'b0;
            seconds_left_nxt_s = 8'd0;
        end
    end

    // Registered outputs and the saturating session counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            feed_r         <= 1'b0;
            motor_en_r     <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            rejected_r     <= 1'b0;
            seconds_left_r <= 8'd0;
            feed_count_r   <= 16'd0;
        end else begin
            feed_r         <= feed_nxt_s;
            motor_en_r     <= motor_nxt_s;
            busy_r         <= busy_nxt_s;
            done_r         <= done_nxt_s;
            rejected_r     <= rejected_nxt_s;
            seconds_left_r <= seconds_left_nxt_s;
            if (done_nxt_s) begin
                feed_count_r <= sat_inc(feed_count_r);
            end else begin
                feed_count_r <= feed_count_r;
            end
        end
    end

    assign bus.feed         = feed_r;
    assign bus.duration     = duration_r;
    assign bus.seconds_left = seconds_left_r;
    assign bus.motor_en     = motor_en_r;
    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.rejected     = rejected_r;
    assign bus.feed_count   = feed_count_r;
endmodule

// File: doc/feed_sequencer.md
Name: feed_sequencer

Overview:
- Upstream control stage for the feeding display. Turns a one-cycle feed request and a portion selection into a timed feeding session: the `feed` level, a fixed `duration` word and motor enable.
- `feed` and `duration` connect directly to the display block's `feed`/`duration` inputs. The display block animates while `feed` is high and expects `feed` to stay high for exactly (duration+1) seconds.
- Adds a post-feed cooldown and a saturating session counter.

Parameters:
- CLK_HZ, 50000000, clock cycles per second (prescaler terminal count + 1); benches override with a small value.
- DUR_SMALL, 4, duration in seconds for portion 0.
- DUR_MED, 6, duration in seconds for portion 1.
- DUR_LARGE, 11, duration in seconds for portion 2.
- COOLDOWN_S, 5, seconds the block stays busy after a session before accepting a new start.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle feed request
- portion  input  2  0 small, 1 medium, 2 large, 3 invalid
- abort  input  1  terminate the current session
- feed  output  1  session-active level to the display block
- duration  output  32  latched session duration in seconds, zero-extended
- seconds_left  output  8  whole seconds remaining in FEEDING, otherwise 0
- motor_en  output  1  dispenser motor enable
- busy  output  1  high in FEEDING or COOLDOWN
- done  output  1  one-cycle pulse on normal completion
- rejected  output  1  one-cycle pulse when a start is refused
- feed_count  output  16  completed sessions, saturating

Behaviour:
- Reset (async, active-high) forces: state IDLE, feed=0, duration=0, seconds_left=0, motor_en=0, busy=0, done=0, rejected=0, feed_count=0, prescaler=0, elapsed=0. Deassertion takes effect at the next clk edge.
- All outputs are registered; no combinational path from inputs to outputs.
- State IDLE: feed=0, busy=0, and `duration` holds its last latched value.
  - start=1 with portion 0–2 and abort=0 → latch duration = DUR_x; clear prescaler and elapsed; go to FEEDING. feed=1 on the following cycle (latency 1).
  - start=1 with portion=3 → rejected pulses for 1 cycle; stay in IDLE.
  - start=1 together with abort=1 → abort wins: start is ignored and rejected stays 0.
- State FEEDING: feed=1, busy=1.
  - Prescaler counts 0..CLK_HZ-1 and wraps. On each wrap, elapsed increments.
  - seconds_left = duration+1-elapsed (8-bit; the value is at most DUR_LARGE+1).
  - motor_en=1 while elapsed < duration; motor_en=0 during the final (duration+1)th second so the display animation completes with the motor off.
  - Normal exit: on the wrap where elapsed becomes duration+1, go to COOLDOWN. Total feed-high time is exactly (duration+1)*CLK_HZ cycles. On that edge: done pulses, feed_count increments, saturating at 16'hFFFF.
  - abort=1 → go to COOLDOWN. feed and motor_en are 0 on the next cycle; no done pulse; feed_count unchanged.
  - start=1 → rejected pulses; the session is unaffected.
- State COOLDOWN: feed=0, motor_en=0, busy=1, seconds_left=0.
  - Lasts COOLDOWN_S*CLK_HZ cycles, then goes to IDLE.
  - start=1 → rejected pulses. abort is ignored.
- `duration` changes only on an accepted start. It stays stable through FEEDING, COOLDOWN and IDLE, so the display block never sees `duration` change while feed=1.
- done and rejected never assert in the same cycle.
- Reset mid-session: feed drops immediately (async), the session is lost and feed_count clears.

Test Plan:
- CLK_HZ=10. Reset, then start with portion=0 → feed=1 on the next cycle and stays high exactly 50 cycles; duration=4; motor_en high for 40 cycles; done pulses once; feed_count=1; busy falls 50 cycles after feed falls (COOLDOWN_S=5).
- Portion=2 → duration=11, feed high 120 cycles. Sample seconds_left → 12 at session start, decrementing to 1 in the last second, then 0 in COOLDOWN.
- Abort 25 cycles into a portion-1 session → feed=0 on the next cycle; no done pulse; feed_count unchanged; busy stays high 50 more cycles.
- Start with portion=3 in IDLE → single rejected pulse; feed stays 0. Start during FEEDING and during COOLDOWN → rejected pulse each time; duration unchanged.
- Start and abort in the same cycle while in IDLE → state stays IDLE; rejected=0.
- Assert reset mid-FEEDING → feed, motor_en and busy drop without waiting for a clock edge; feed_count=0. With feed_count preset to 16'hFFFF (force), complete a session → count stays 16'hFFFF.
